// File: rtl/ahb_prior_aging_ctrl.sv
// Per-master priority aging for an AHB dynamic-priority arbiter.
// Pending masters gain one priority step per AGE_LIMIT waiting cycles.
module ahb_prior_aging_ctrl #(
  parameter int MASTER_NUM = 2,
  parameter int PRIOR_BIT  = 2,
  parameter int AGE_LIMIT  = 8
) (
  input  logic                            hclk,
  input  logic                            hreset_n,
  input  logic [MASTER_NUM-1:0]           hreq,
  input  logic [MASTER_NUM-1:0]           grant,
  input  logic [MASTER_NUM-1:0]           hlast,
  input  logic                            hwait,
  input  logic                            cfg_wr,
  input  logic [3:0]                      cfg_idx,
  input  logic [PRIOR_BIT-1:0]            cfg_data,
  output logic [MASTER_NUM*PRIOR_BIT-1:0] hprior,
  output logic [MASTER_NUM-1:0]           starve
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_OWN  = 2'd2;

  localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT - 1);
  localparam logic [PRIOR_BIT-1:0] EFF_MAX = '1;

  for (genvar i = 0; i < MASTER_NUM; i++) begin : g_m
    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [PRIOR_BIT-1:0] base_q, base_d;
    logic [PRIOR_BIT-1:0] eff_q, eff_d;
    logic                 cfg_hit;
    logic                 own_done;

    assign cfg_hit  = cfg_wr && (32'(cfg_idx) == i);
    assign own_done = hlast[i] && grant[i] && !hwait;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      eff_d   = eff_q;
      if (cfg_hit) base_d = cfg_data;
      case (state_q)
        S_IDLE: begin
          if (grant[i]) begin
            state_d = S_OWN;
          end else if (hreq[i]) begin
            state_d = S_PEND;
          end else if (cfg_hit) begin
            eff_d = cfg_data;
          end
        end
        S_PEND: begin
          if (grant[i]) begin
            state_d = S_OWN;
            cnt_d   = '0;
          end else if (!hreq[i]) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            eff_d   = cfg_hit ? cfg_data : base_q;
          end else if (cnt_q == AGE_MAX) begin
            // aging step beats a coincident cfg write on eff
            cnt_d = '0;
            if (eff_q != EFF_MAX) eff_d = eff_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_OWN: begin
          cnt_d = '0;
          if (own_done) begin
            state_d = S_IDLE;
            eff_d   = cfg_hit ? cfg_data : base_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        base_q  <= PRIOR_BIT'(i);
        eff_q   <= PRIOR_BIT'(i);
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        base_q  <= base_d;
        eff_q   <= eff_d;
      end
    end

    assign hprior[i*PRIOR_BIT +: PRIOR_BIT] = eff_q;
    assign starve[i] = (state_q == S_PEND) && (eff_q == EFF_MAX);
  end

endmodule
